// File: rtl/writeback_stage_p_pkg.sv
// Shared constants for the writeback stage and the load extender:
// result-select encodings and load funct3 codes.
package writeback_stage_p_pkg;

  localparam int unsigned RES_W = 2;
  localparam int unsigned F3_W  = 3;

  // Result source selected in writeback.
  typedef enum logic [RES_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  // Load size/sign codes (funct3 of the load opcode).
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational sub-word load extraction and sign/zero extension.
//   read_data : raw data-memory word
//   off       : byte offset within the word (address bits [1:0])
//   funct3    : load size/sign code
//   ext_data  : extracted, extended load value
module load_extend
  import writeback_stage_p_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [1:0]      off,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Byte lane picked by the full offset.
  always_comb begin
    byte_sel = read_data[7:0];
    case (off)
      2'd0: byte_sel = read_data[7:0];
      2'd1: byte_sel = read_data[15:8];
      2'd2: byte_sel = read_data[23:16];
      2'd3: byte_sel = read_data[31:24];
      default: byte_sel = read_data[7:0];
    endcase
  end

  // Halfword lane uses off[1] only; misaligned halves never reach here.
  assign half_sel = off[1] ? read_data[31:16] : read_data[15:0];
  assign word_sel = read_data[31:0];

  always_comb begin
    ext_data = read_data;
    case (funct3)
      F3_LB:   ext_data = XLEN'($signed(byte_sel));
      F3_LH:   ext_data = XLEN'($signed(half_sel));
      F3_LW:   ext_data = XLEN'($signed(word_sel));
      F3_LBU:  ext_data = XLEN'(byte_sel);
      F3_LHU:  ext_data = XLEN'(half_sel);
      default: ext_data = read_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage_p.sv
// Writeback stage: MEM/WB pipeline register with stall/flush, load
// extraction, four-way result select, gated register-file write and a
// retired-instruction counter.
//   clk, rst            : clock, async active-high reset
//   stall_i, flush_i    : hold / bubble the WB register (flush wins)
//   *M inputs           : memory-stage instruction fields
//   ValidW, RegWriteW   : WB slot valid, gated rd write enable (never x0)
//   RdW, ResultW        : destination register and writeback data
//   InstRetW            : count of instructions captured into WB
module writeback_stage_p
  import writeback_stage_p_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic [REGADDR_W-1:0] RdM,
  input  logic [RES_W-1:0]     ResultSrcM,
  input  logic [F3_W-1:0]      Funct3M,
  input  logic [XLEN-1:0]      ALU_ResultM,
  input  logic [XLEN-1:0]      ReadDataM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      ImmExtM,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic [REGADDR_W-1:0] RdW,
  output logic [XLEN-1:0]      ResultW,
  output logic [CNT_W-1:0]     InstRetW
);

  logic                 valid_q;
  logic                 reg_write_q;
  logic [REGADDR_W-1:0] rd_q;
  res_src_e             result_src_q;
  logic [F3_W-1:0]      funct3_q;
  logic [XLEN-1:0]      alu_result_q;
  logic [XLEN-1:0]      read_data_q;
  logic [XLEN-1:0]      pc_plus4_q;
  logic [XLEN-1:0]      imm_ext_q;
  logic [CNT_W-1:0]     inst_ret_q;
  logic [XLEN-1:0]      load_data;
  logic                 capture;

  assign capture = !stall_i && !flush_i;

  // MEM/WB register: flush loads a zeroed bubble, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= RES_ALU;
      funct3_q     <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= RES_ALU;
      funct3_q     <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
    end else if (!stall_i) begin
      valid_q      <= ValidM;
      reg_write_q  <= RegWriteM;
      rd_q         <= RdM;
      result_src_q <= res_src_e'(ResultSrcM);
      funct3_q     <= Funct3M;
      alu_result_q <= ALU_ResultM;
      read_data_q  <= ReadDataM;
      pc_plus4_q   <= PCPlus4M;
      imm_ext_q    <= ImmExtM;
    end
  end

  // Counts at capture time so a stalled instruction is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_ret_q <= '0;
    end else if (capture && ValidM) begin
      inst_ret_q <= inst_ret_q + CNT_W'(1);
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .read_data (read_data_q),
    .off       (alu_result_q[1:0]),
    .funct3    (funct3_q),
    .ext_data  (load_data)
  );

  // Result select straight from the registered fields.
  always_comb begin
    ResultW = alu_result_q;
    case (result_src_q)
      RES_ALU: ResultW = alu_result_q;
      RES_MEM: ResultW = load_data;
      RES_PC4: ResultW = pc_plus4_q;
      RES_IMM: ResultW = imm_ext_q;
      default: ResultW = alu_result_q;
    endcase
  end

  assign ValidW    = valid_q;
  assign RdW       = rd_q;
  assign RegWriteW = reg_write_q && valid_q && (rd_q != '0);
  assign InstRetW  = inst_ret_q;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed bench for writeback_stage_p: vector table for the
// single-cycle datapath, hand sequences for stall/flush, async reset
// and counter wrap (a second instance with a 4-bit counter).
module tb_writeback_stage_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic        ValidM, RegWriteM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;

  logic        ValidW, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [63:0] InstRetW;

  logic        ValidW_s, RegWriteW_s;
  logic [4:0]  RdW_s;
  logic [31:0] ResultW_s;
  logic [3:0]  InstRetW_s;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_stage_p dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .InstRetW(InstRetW)
  );

  writeback_stage_p #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM),
    .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .ValidW(ValidW_s), .RegWriteW(RegWriteW_s), .RdW(RdW_s),
    .ResultW(ResultW_s), .InstRetW(InstRetW_s)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        exp_we;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] imm);
    ValidM = v; RegWriteM = we; RdM = rd; ResultSrcM = src; Funct3M = f3;
    ALU_ResultM = alu; PCPlus4M = pc4; ImmExtM = imm;
  endtask

  initial begin
    // valid we rd src f3 alu pc4 imm | exp_we exp_res
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  2'b01, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF82};
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  2'b01, 3'b100, 32'h1000, 32'h0, 32'h0, 1'b1, 32'h0000_0082};
    vecs[2]  = '{1'b1, 1'b1, 5'd7,  2'b01, 3'b000, 32'h1001, 32'h0, 32'h0, 1'b1, 32'h0000_007F};
    vecs[3]  = '{1'b1, 1'b1, 5'd8,  2'b01, 3'b001, 32'h1002, 32'h0, 32'h0, 1'b1, 32'hFFFF_80F1};
    vecs[4]  = '{1'b1, 1'b1, 5'd9,  2'b01, 3'b101, 32'h1002, 32'h0, 32'h0, 1'b1, 32'h0000_80F1};
    vecs[5]  = '{1'b1, 1'b1, 5'd10, 2'b01, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 32'h80F1_7F82};
    vecs[6]  = '{1'b1, 1'b1, 5'd11, 2'b01, 3'b000, 32'h1003, 32'h0, 32'h0, 1'b1, 32'hFFFF_FF80};
    vecs[7]  = '{1'b1, 1'b1, 5'd12, 2'b01, 3'b001, 32'h1000, 32'h0, 32'h0, 1'b1, 32'h0000_7F82};
    vecs[8]  = '{1'b1, 1'b1, 5'd13, 2'b01, 3'b011, 32'h1001, 32'h0, 32'h0, 1'b1, 32'h80F1_7F82};
    vecs[9]  = '{1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h10, 32'h104, 32'h1234_5000, 1'b1, 32'h10};
    vecs[10] = '{1'b1, 1'b1, 5'd15, 2'b10, 3'b000, 32'h10, 32'h104, 32'h1234_5000, 1'b1, 32'h104};
    vecs[11] = '{1'b1, 1'b1, 5'd16, 2'b11, 3'b000, 32'h10, 32'h104, 32'h1234_5000, 1'b1, 32'h1234_5000};
    vecs[12] = '{1'b1, 1'b1, 5'd0,  2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 1'b0, 32'h55};
    vecs[13] = '{1'b0, 1'b1, 5'd3,  2'b00, 3'b000, 32'h66, 32'h0, 32'h0, 1'b0, 32'h66};
    vecs[14] = '{1'b1, 1'b0, 5'd9,  2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 1'b0, 32'h77};
    vecs[15] = '{1'b1, 1'b1, 5'd17, 2'b01, 3'b101, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h0000_80F1};

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    ReadDataM = 32'h80F1_7F82;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    exp_cnt = '0;
    #12;
    chk("rst_valid", 64'(ValidW), 64'd0);
    chk("rst_we", 64'(RegWriteW), 64'd0);
    chk("rst_rd", 64'(RdW), 64'd0);
    chk("rst_result", 64'(ResultW), 64'd0);
    chk("rst_cnt", InstRetW, 64'd0);
    rst = 1'b0;
    step();

    // Datapath vectors, one capture per cycle.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].rd, vecs[i].src, vecs[i].f3,
            vecs[i].alu, vecs[i].pc4, vecs[i].imm);
      step();
      if (vecs[i].valid) exp_cnt = exp_cnt + 64'd1;
      chk($sformatf("vec%0d_valid", i), 64'(ValidW), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_we", i), 64'(RegWriteW), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rd", i), 64'(RdW), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_result", i), 64'(ResultW), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_cnt", i), InstRetW, exp_cnt);
    end

    // Capture rd=7, then stall three cycles with changing M inputs.
    drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h0000_0777, 32'h0, 32'h0);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("cap_rd", 64'(RdW), 64'd7);
    chk("cap_we", 64'(RegWriteW), 64'd1);
    chk("cap_cnt", InstRetW, exp_cnt);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'(20 + i), 2'b10, 3'b001, 32'($urandom), 32'hABC0, 32'h0);
      step();
      chk($sformatf("stall%0d_rd", i), 64'(RdW), 64'd7);
      chk($sformatf("stall%0d_we", i), 64'(RegWriteW), 64'd1);
      chk($sformatf("stall%0d_result", i), 64'(ResultW), 64'h777);
      chk($sformatf("stall%0d_cnt", i), InstRetW, exp_cnt);
    end

    // Flush together with stall: bubble wins, counter untouched.
    flush_i = 1'b1;
    step();
    chk("flush_valid", 64'(ValidW), 64'd0);
    chk("flush_we", 64'(RegWriteW), 64'd0);
    chk("flush_rd", 64'(RdW), 64'd0);
    chk("flush_cnt", InstRetW, exp_cnt);
    flush_i = 1'b0; stall_i = 1'b0;

    // Rebuild a live slot, then reset asynchronously between edges.
    drive(1'b1, 1'b1, 5'd4, 2'b11, 3'b000, 32'h0, 32'h0, 32'hCAFE_0000);
    step();
    exp_cnt = exp_cnt + 64'd1;
    chk("pre_rst_cnt", InstRetW, exp_cnt);
    chk("pre_rst_cnt_small", 64'(InstRetW_s), 64'(exp_cnt[3:0]));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(ValidW), 64'd0);
    chk("async_rst_we", 64'(RegWriteW), 64'd0);
    chk("async_rst_rd", 64'(RdW), 64'd0);
    chk("async_rst_result", 64'(ResultW), 64'd0);
    chk("async_rst_cnt", InstRetW, 64'd0);
    // Reset held across edges with stall and flush active still wins.
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    stall_i = 1'b0; flush_i = 1'b0;
    step();
    chk("rst_hold_cnt", InstRetW, 64'd0);
    chk("rst_hold_valid", 64'(ValidW), 64'd0);
    rst = 1'b0;
    exp_cnt = '0;

    // 17 valid captures: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 2'b00, 3'b000, 32'(i), 32'h0, 32'h0);
      step();
      exp_cnt = exp_cnt + 64'd1;
      if (i == 15) chk("wrap16_small", 64'(InstRetW_s), 64'd0);
    end
    chk("wrap17_small", 64'(InstRetW_s), 64'd1);
    chk("wrap17_main", InstRetW, 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage_p.md
Name: writeback_stage_p

Overview:
Parametrised next-generation writeback stage for the pipelined RISC-V core.
- Owns the MEM/WB pipeline register, with stall and flush.
- Extracts and sign/zero-extends sub-word load data.
- Selects the result from four sources.
- Gates the register-file write and keeps a retired-instruction counter.
- Sits between the memory stage and the register file / forwarding unit.

Parameters:
XLEN, 32, datapath width (32 or 64; load extraction covers byte/half/word only).
REGADDR_W, 5, register-file address width.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  pipeline clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall_i  input  1  hold the WB register contents.
flush_i  input  1  load a bubble into the WB register.
ValidM  input  1  memory-stage instruction is valid.
RegWriteM  input  1  instruction writes rd.
RdM  input  REGADDR_W  destination register.
ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
Funct3M  input  3  load size/sign code.
ALU_ResultM  input  XLEN  ALU result / load address.
ReadDataM  input  XLEN  raw data-memory word.
PCPlus4M  input  XLEN  return address.
ImmExtM  input  XLEN  extended immediate (LUI).
ValidW  output  1  WB slot holds a valid instruction.
RegWriteW  output  1  gated register-file write enable.
RdW  output  REGADDR_W  destination register.
ResultW  output  XLEN  writeback data.
InstRetW  output  CNT_W  retired-instruction count.

Behaviour:
- **Reset:** rst asserted clears all WB registers and InstRetW to 0 immediately (asynchronous). Outputs are then ValidW=0, RegWriteW=0, RdW=0, ResultW=0.
- **Register update priority** at each rising clk:
  - flush_i=1: ValidW and RegWrite are cleared; the other fields are don't-care and are loaded as 0. Flush overrides stall.
  - stall_i=1 (and no flush): all fields hold.
  - otherwise: all M-side inputs are captured.
- **Latency:** one cycle from M inputs to W outputs. ResultW is combinational from the registered fields; it has no extra register.
- **RegWriteW:** equals registered RegWrite AND ValidW AND (RdW != 0). It is never asserted for x0.
- **Result mux:**
  - 00: ALU_ResultW.
  - 01: extracted load data.
  - 10: PCPlus4W.
  - 11: ImmExtW.
- **Load extraction:** uses off = ALU_ResultW[1:0].
  - Byte: ReadDataW[8*off+7 : 8*off].
  - Half: upper half if off[1]=1, else lower half; off[0] is ignored, because misalignment is trapped upstream.
  - Funct3 000 LB and 001 LH sign-extend to XLEN.
  - Funct3 100 LBU and 101 LHU zero-extend.
  - Funct3 010 LW: word, sign-extended to XLEN.
  - Any other Funct3: pass ReadDataW[XLEN-1:0] unchanged.
- **InstRetW:**
  - Increments by 1 on each clock edge that captures an instruction with ValidM=1, stall_i=0 and flush_i=0.
  - It therefore counts each instruction exactly once, even if that instruction is later held by a stall.
  - Wraps from 2^CNT_W-1 to 0 silently.
- **Stall while a valid instruction is held:** RegWriteW stays asserted, so the same value is re-written. This is required to be harmless.
- **Reset during stall or flush:** reset wins; the counter is cleared.

Decomposition:
- Shared package holds:
  - result-select encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_IMM=2'b11;
  - load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One sub-module: load_extend (combinational; inputs ReadData, off, funct3; output extended data), reusable by a future LSU.

Test Plan:
1. **Reset:** rst=1 mid-stream with InstRetW=5 -> all outputs and InstRetW are 0 immediately, without waiting for a clk edge.
2. **Loads:** ReadDataM=32'h80F1_7F82, ResultSrcM=01.
   - LB, off=0 -> ResultW=32'hFFFF_FF82.
   - LBU, off=0 -> 32'h0000_0082.
   - LB, off=1 -> 32'h0000_007F.
   - LH, off=2 -> 32'hFFFF_80F1.
   - LHU, off=2 -> 32'h0000_80F1.
   - LW -> 32'h80F1_7F82.
3. **Result select:** ALU=0x10, PC+4=0x104, Imm=0x12345000. ResultSrcM=00 / 10 / 11 -> ResultW = 0x10 / 0x104 / 0x12345000, each one cycle after capture.
4. **x0 write:** RdM=0, RegWriteM=1, ValidM=1 -> RegWriteW=0 and ValidW=1; InstRetW still increments.
5. **Stall/flush:**
   - Capture rd=7, then stall 3 cycles while M inputs change -> RdW stays 7 and InstRetW +1 total.
   - Then flush_i=1 together with stall_i=1 -> next cycle ValidW=0, RegWriteW=0, and InstRetW is unchanged.
6. **Counter wrap:** CNT_W=4, 17 valid captured instructions -> InstRetW=1.
